// File: rtl/irq_hub_if.sv
// Bus and CP0 acknowledge signals of the interrupt hub.
// The master side is the system bridge and CP0; the slave side is irq_hub.
interface irq_hub_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ack_valid;
  logic [2:0]  ack_id;

  modport master (
    output addr,
    output we,
    output wd,
    output ack_valid,
    output ack_id,
    input  rd
  );

  modport slave (
    input  addr,
    input  we,
    input  wd,
    input  ack_valid,
    input  ack_id,
    output rd
  );
endinterface

// File: rtl/irq_hub.sv
// Interrupt hub: synchronises request lines, latches them as level or edge,
// and presents a masked, prioritised vector plus a 4-word register window.
module irq_hub #(
  parameter int N_SRC       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  irq_hub_if.slave         bus,
  output logic [N_SRC-1:0] hw_int,
  output logic             int_req
);

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_MODE = 2'd2;
  localparam logic [1:0] ADDR_ID   = 2'd3;

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q, sync_d;
  logic [N_SRC-1:0] hist_q, hist_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] hw_int_q, hw_int_d;
  logic             int_req_q, int_req_d;

  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] wr_clr;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] active;
  logic [2:0]       id_val;
  logic             unused_wd_bits;

  assign unused_wd_bits = ^bus.wd[31:N_SRC];

  always_comb begin
    sync_d[0] = irq_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign hist_d = s;
  assign rise   = s & ~hist_q;

  always_comb begin
    wr_clr  = '0;
    ack_clr = '0;
    mask_d  = mask_q;
    mode_d  = mode_q;
    if (bus.we) begin
      case (bus.addr)
        ADDR_MASK: mask_d = bus.wd[N_SRC-1:0];
        ADDR_PEND: wr_clr = bus.wd[N_SRC-1:0];
        ADDR_MODE: mode_d = bus.wd[N_SRC-1:0];
        default:   ;
      endcase
    end
    // Out-of-range ack ids simply match no source.
    for (int i = 0; i < N_SRC; i++) begin
      if (bus.ack_valid && (32'(bus.ack_id) == i)) begin
        ack_clr[i] = 1'b1;
      end
    end
    clr = wr_clr | ack_clr;
  end

  // Level sources track the synchronised line; edge sources let a new rise beat a clear.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode_q[i]) begin
        pend_d[i] = rise[i] | (pend_q[i] & ~clr[i]);
      end else begin
        pend_d[i] = s[i];
      end
    end
    hw_int_d  = pend_d & mask_d;
    int_req_d = |hw_int_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      hist_q    <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      mode_q    <= '0;
      hw_int_q  <= '0;
      int_req_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      mode_q    <= mode_d;
      hw_int_q  <= hw_int_d;
      int_req_q <= int_req_d;
    end
  end

  assign hw_int  = hw_int_q;
  assign int_req = int_req_q;

  // Lowest index wins, so scan from the top down and let lower bits overwrite.
  always_comb begin
    active = pend_q & mask_q;
    id_val = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        id_val = 3'(i + 1);
      end
    end
  end

  always_comb begin
    bus.rd = '0;
    case (bus.addr)
      ADDR_MASK: bus.rd = 32'(mask_q);
      ADDR_PEND: bus.rd = 32'(pend_q);
      ADDR_MODE: bus.rd = 32'(mode_q);
      ADDR_ID:   bus.rd = 32'(id_val);
      default:   bus.rd = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_hub.sv
// Directed bench for irq_hub: reset, level/edge capture, masking, priority,
// set/clear collision, ack handling and asynchronous reset.
module tb_irq_hub;
  logic       clk;
  logic       rst_n;
  logic [5:0] irq_in;
  logic [5:0] hw_int;
  logic       int_req;
  int         checks;
  int         fails;

  irq_hub_if bus_if ();

  irq_hub #(
    .N_SRC      (6),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_in (irq_in),
    .bus    (bus_if.slave),
    .hw_int (hw_int),
    .int_req(int_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.addr = a;
    bus_if.wd   = d;
    bus_if.we   = 1'b1;
    tick(1);
    bus_if.we   = 1'b0;
    bus_if.wd   = '0;
  endtask

  task automatic check_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus_if.addr = a;
    #1;
    check_output(tag, bus_if.rd, exp);
  endtask

  initial begin
    checks           = 0;
    fails            = 0;
    rst_n            = 1'b0;
    irq_in           = '0;
    bus_if.addr      = '0;
    bus_if.we        = 1'b0;
    bus_if.wd        = '0;
    bus_if.ack_valid = 1'b0;
    bus_if.ack_id    = '0;

    tick(3);
    rst_n = 1'b1;
    tick(1);
    check_output("idle_hw_int", 32'(hw_int), 32'h0);
    check_output("idle_int_req", 32'(int_req), 32'h0);
    check_read("idle_mask", 2'd0, 32'h0);
    check_read("idle_pend", 2'd1, 32'h0);
    check_read("idle_mode", 2'd2, 32'h0);
    check_read("idle_id", 2'd3, 32'h0);

    // Level path on source 0
    bus_write(2'd0, 32'h01);
    irq_in[0] = 1'b1;
    tick(2);
    check_output("lvl_int_req_early", 32'(int_req), 32'h0);
    tick(1);
    check_output("lvl_int_req_on", 32'(int_req), 32'h1);
    check_output("lvl_hw_int", 32'(hw_int), 32'h01);
    bus_write(2'd1, 32'h01);
    check_read("lvl_pend_after_clr", 2'd1, 32'h01);
    tick(1);
    check_read("lvl_pend_hold", 2'd1, 32'h01);
    irq_in[0] = 1'b0;
    tick(2);
    check_output("lvl_int_req_still", 32'(int_req), 32'h1);
    tick(1);
    check_output("lvl_int_req_off", 32'(int_req), 32'h0);
    check_read("lvl_pend_off", 2'd1, 32'h0);

    // Edge pulse on source 1, then CP0 ack
    bus_write(2'd2, 32'h02);
    bus_write(2'd0, 32'h02);
    irq_in[1] = 1'b1;
    tick(1);
    irq_in[1] = 1'b0;
    tick(4);
    check_read("edge_pend", 2'd1, 32'h02);
    check_read("edge_id", 2'd3, 32'h2);
    check_output("edge_int_req", 32'(int_req), 32'h1);
    tick(3);
    check_read("edge_pend_persist", 2'd1, 32'h02);
    bus_if.ack_valid = 1'b1;
    bus_if.ack_id    = 3'd1;
    tick(1);
    bus_if.ack_valid = 1'b0;
    check_read("edge_ack_pend", 2'd1, 32'h0);
    check_output("edge_ack_int_req", 32'(int_req), 32'h0);

    // Masking and priority, all sources edge
    bus_write(2'd0, 32'h00);
    bus_write(2'd2, 32'h3F);
    irq_in = 6'h28;
    tick(1);
    irq_in = 6'h00;
    tick(4);
    check_output("mask0_int_req", 32'(int_req), 32'h0);
    check_read("mask0_pend", 2'd1, 32'h28);
    check_read("mask0_id", 2'd3, 32'h0);
    bus_write(2'd0, 32'hFFFF_FF3F);
    check_read("mask_rd_trunc", 2'd0, 32'h3F);
    check_read("prio_id_4", 2'd3, 32'h4);
    check_output("prio_hw_int", 32'(hw_int), 32'h28);
    bus_write(2'd1, 32'h08);
    check_read("prio_id_6", 2'd3, 32'h6);
    check_output("prio_hw_int_b5", 32'(hw_int), 32'h20);
    bus_write(2'd1, 32'h20);
    check_read("prio_pend_clr", 2'd1, 32'h0);

    // Ack out of range ignored; ack and bus clear combine
    irq_in = 6'h03;
    tick(1);
    irq_in = 6'h00;
    tick(4);
    check_read("ack_setup_pend", 2'd1, 32'h03);
    bus_if.ack_valid = 1'b1;
    bus_if.ack_id    = 3'd7;
    tick(1);
    bus_if.ack_valid = 1'b0;
    check_read("ack_oob_ignored", 2'd1, 32'h03);
    bus_if.ack_valid = 1'b1;
    bus_if.ack_id    = 3'd0;
    bus_write(2'd1, 32'h02);
    bus_if.ack_valid = 1'b0;
    check_read("ack_or_write", 2'd1, 32'h0);

    // New rise on bit 2 lands in the same cycle as its clear
    irq_in[2] = 1'b1;
    tick(1);
    irq_in[2] = 1'b0;
    tick(4);
    check_read("coll_setup", 2'd1, 32'h04);
    irq_in[2] = 1'b1;
    tick(2);
    bus_write(2'd1, 32'h04);
    check_read("coll_set_wins", 2'd1, 32'h04);
    bus_write(2'd1, 32'h04);
    check_read("coll_plain_clr", 2'd1, 32'h0);
    irq_in[2] = 1'b0;
    tick(3);

    // Asynchronous reset while source 0 is requesting
    irq_in[0] = 1'b1;
    tick(4);
    check_output("rst_pre_int_req", 32'(int_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_async_hw_int", 32'(hw_int), 32'h0);
    check_output("rst_async_int_req", 32'(int_req), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(4);
    check_output("rst_after_int_req", 32'(int_req), 32'h0);
    check_output("rst_after_hw_int", 32'(hw_int), 32'h0);
    bus_write(2'd2, 32'h01);
    bus_write(2'd1, 32'h01);
    bus_write(2'd0, 32'h01);
    tick(3);
    check_read("rst_no_repend", 2'd1, 32'h0);
    check_output("rst_no_int_req", 32'(int_req), 32'h0);
    irq_in[0] = 1'b0;
    tick(3);
    irq_in[0] = 1'b1;
    tick(3);
    check_output("rst_new_rise_int_req", 32'(int_req), 32'h1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
